// File: rtl/pipeline_ex_stage_pkg.sv
// Shared definitions for the EX stage: datapath width, ALU op codes,
// the iterative-unit FSM states and small helpers.
package rvcpu_ex_pkg;

    localparam int XLEN = 64;
    localparam int ITER = 64;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_PASSB  = 5'd10,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ex_state_e;

    function automatic logic is_muldiv(input logic [4:0] op);
        return op inside {[5'd16:5'd23]};
    endfunction

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/pipeline_ex_stage_if.sv
// ID->EX operand/control bundle and the EX->MEM register outputs.
// master drives the ID side (upstream), slave is the EX stage itself.
interface pipeline_ex_stage_if;
    import rvcpu_ex_pkg::*;

    logic            valid_ID;
    logic [XLEN-1:0] pc_ID;
    logic [XLEN-1:0] rs1_data_ID;
    logic [XLEN-1:0] rs2_data_ID;
    logic [XLEN-1:0] imm_ID;
    logic [4:0]      rd_ID;
    logic [4:0]      alu_ctrl_ID;
    logic            word_ID;
    logic            a_sel_ID;
    logic            b_sel_ID;
    logic [2:0]      dm_rd_ctrl_ID;
    logic [1:0]      dm_wr_ctrl_ID;
    logic            rf_wr_en_ID;
    logic [1:0]      rf_wr_sel_ID;
    logic            flush_EX;

    logic [XLEN-1:0] alu_result_EX;
    logic [XLEN-1:0] reg_data2_EX;
    logic [XLEN-1:0] pc_EX;
    logic [4:0]      rd_EX;
    logic [2:0]      dm_rd_ctrl_EX;
    logic [1:0]      dm_wr_ctrl_EX;
    logic            rf_wr_en_EX;
    logic [1:0]      rf_wr_sel_EX;
    logic            valid_EX;
    logic            stall_EX;

    modport master (
        output valid_ID, pc_ID, rs1_data_ID, rs2_data_ID, imm_ID, rd_ID,
               alu_ctrl_ID, word_ID, a_sel_ID, b_sel_ID, dm_rd_ctrl_ID,
               dm_wr_ctrl_ID, rf_wr_en_ID, rf_wr_sel_ID, flush_EX,
        input  alu_result_EX, reg_data2_EX, pc_EX, rd_EX, dm_rd_ctrl_EX,
               dm_wr_ctrl_EX, rf_wr_en_EX, rf_wr_sel_EX, valid_EX, stall_EX
    );

    modport slave (
        input  valid_ID, pc_ID, rs1_data_ID, rs2_data_ID, imm_ID, rd_ID,
               alu_ctrl_ID, word_ID, a_sel_ID, b_sel_ID, dm_rd_ctrl_ID,
               dm_wr_ctrl_ID, rf_wr_en_ID, rf_wr_sel_ID, flush_EX,
        output alu_result_EX, reg_data2_EX, pc_EX, rd_EX, dm_rd_ctrl_EX,
               dm_wr_ctrl_EX, rf_wr_en_EX, rf_wr_sel_EX, valid_EX, stall_EX
    );

endinterface

// File: rtl/pipeline_ex_stage_muldiv.sv
// Iterative radix-2 multiply (shift-add) / divide (restoring) unit on operand
// magnitudes; the sign is applied on the final iteration, which drives done_o.
module ex_muldiv
    import rvcpu_ex_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [4:0]      op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    ex_state_e           state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [4:0]          op_q, op_d;
    logic                word_q, word_d;
    logic                neg_q, neg_d;
    logic                negr_q, negr_d;

    logic                sa, sb, wd;
    logic [XLEN-1:0]     a_ext, b_ext, a_mag, b_mag;
    logic [XLEN:0]       mul_sum;
    logic [XLEN-1:0]     div_low;
    logic                div_ge;
    logic [2*XLEN-1:0]   step, prod;
    logic [XLEN-1:0]     quo, rem, raw;

    always_comb begin
        sa    = op_i inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
        sb    = op_i inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
        wd    = word_i && (op_i inside {ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU});
        a_ext = wd ? (sa ? sext32(a_i[31:0]) : {32'b0, a_i[31:0]}) : a_i;
        b_ext = wd ? (sb ? sext32(b_i[31:0]) : {32'b0, b_i[31:0]}) : b_i;
        a_mag = (sa && a_ext[XLEN-1]) ? -a_ext : a_ext;
        b_mag = (sb && b_ext[XLEN-1]) ? -b_ext : b_ext;
    end

    // One iteration: mul adds into the upper half and shifts right; div shifts
    // the remainder/quotient pair left and subtracts when the divisor fits.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        div_low = {acc_q[2*XLEN-2:XLEN], acc_q[XLEN-1]};
        div_ge  = acc_q[2*XLEN-1] || (div_low >= opnd_q);
        if (!op_q[2])
            step = {mul_sum, acc_q[XLEN-1:1]};
        else if (div_ge)
            step = {div_low - opnd_q, acc_q[XLEN-2:0], 1'b1};
        else
            step = {div_low, acc_q[XLEN-2:0], 1'b0};

        prod = neg_q ? -step : step;
        quo  = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
        rem  = negr_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
        case (op_q)
            ALU_MUL:                          raw = prod[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:  raw = prod[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:                raw = quo;
            default:                          raw = rem;
        endcase
        result_o = word_q ? sext32(raw[31:0]) : raw;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        op_d    = op_q;
        word_d  = word_q;
        neg_d   = neg_q;
        negr_d  = negr_q;
        done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    op_d    = op_i;
                    word_d  = wd;
                    neg_d   = (sa && a_ext[XLEN-1]) ^ (sb && b_ext[XLEN-1]);
                    negr_d  = sa && a_ext[XLEN-1];
                    opnd_d  = op_i[2] ? b_mag : a_mag;
                    acc_d   = {{XLEN{1'b0}}, (op_i[2] ? a_mag : b_mag)};
                end
            end
            BUSY: begin
                acc_d = step;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(ITER - 1)) begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
            done_o  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            op_q    <= '0;
            word_q  <= 1'b0;
            neg_q   <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
            word_q  <= word_d;
            neg_q   <= neg_d;
            negr_q  <= negr_d;
        end
    end

    assign busy_o = (state_q == BUSY);

endmodule

// File: rtl/pipeline_ex_stage.sv
// RV64 execute stage: operand muxes, single-cycle ALU, divide corner cases,
// EX/MEM registers; long mul/div ops are handed to ex_muldiv and stall ID.
module pipeline_ex_stage
    import rvcpu_ex_pkg::*;
(
    input  logic clk,
    input  logic reset,
    pipeline_ex_stage_if.slave ex
);

    function automatic logic [XLEN-1:0] alu(input logic [4:0] op, input logic word,
                                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [XLEN-1:0] sum, dif, r;
        logic [31:0]     sl32, sr32, sra32;
        sum   = a + b;
        dif   = a - b;
        sl32  = a[31:0] << b[4:0];
        sr32  = a[31:0] >> b[4:0];
        sra32 = $signed(a[31:0]) >>> b[4:0];
        r     = '0;
        case (op)
            ALU_ADD:   r = word ? sext32(sum[31:0]) : sum;
            ALU_SUB:   r = word ? sext32(dif[31:0]) : dif;
            ALU_SLL:   r = word ? sext32(sl32) : a << b[5:0];
            ALU_SLT:   r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU:  r = {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR:   r = a ^ b;
            ALU_SRL:   r = word ? sext32(sr32) : a >> b[5:0];
            ALU_SRA:   r = word ? sext32(sra32) : XLEN'($signed(a) >>> b[5:0]);
            ALU_OR:    r = a | b;
            ALU_AND:   r = a & b;
            ALU_PASSB: r = b;
            default:   r = '0;
        endcase
        return r;
    endfunction

    logic [XLEN-1:0] op_a, op_b, dvd, special_res, fast_res, md_result;
    logic            accept, is_div, div_signed, quo_op, div_zero, div_ovf, special;
    logic            md_start, md_busy, md_done;

    logic [XLEN-1:0] res_q, res_d, rd2_q, rd2_d, pc_q, pc_d;
    logic [4:0]      rd_q, rd_d;
    logic [2:0]      dmrd_q, dmrd_d;
    logic [1:0]      dmwr_q, dmwr_d, rfsel_q, rfsel_d;
    logic            rfen_q, rfen_d, valid_q, valid_d;

    logic [XLEN-1:0] h_pc_q, h_pc_d, h_rs2_q, h_rs2_d;
    logic [4:0]      h_rd_q, h_rd_d;
    logic [2:0]      h_dmrd_q, h_dmrd_d;
    logic [1:0]      h_dmwr_q, h_dmwr_d, h_rfsel_q, h_rfsel_d;
    logic            h_rfen_q, h_rfen_d;

    // Divide-by-zero and signed overflow finish here without entering BUSY.
    always_comb begin
        op_a       = ex.a_sel_ID ? ex.pc_ID : ex.rs1_data_ID;
        op_b       = ex.b_sel_ID ? ex.imm_ID : ex.rs2_data_ID;
        is_div     = ex.alu_ctrl_ID inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        div_signed = ex.alu_ctrl_ID inside {ALU_DIV, ALU_REM};
        quo_op     = ex.alu_ctrl_ID inside {ALU_DIV, ALU_DIVU};
        dvd        = ex.word_ID ? sext32(op_a[31:0]) : op_a;
        div_zero   = ex.word_ID ? (op_b[31:0] == 32'd0) : (op_b == '0);
        div_ovf    = div_signed && (ex.word_ID
                       ? (op_a[31:0] == 32'h8000_0000 && op_b[31:0] == 32'hFFFF_FFFF)
                       : (op_a == {1'b1, {(XLEN-1){1'b0}}} && op_b == '1));
        special     = is_div && (div_zero || div_ovf);
        special_res = div_zero ? (quo_op ? '1 : dvd) : (quo_op ? dvd : '0);
        fast_res    = special ? special_res : alu(ex.alu_ctrl_ID, ex.word_ID, op_a, op_b);
        accept      = ex.valid_ID && !md_busy && !ex.flush_EX;
        md_start    = accept && is_muldiv(ex.alu_ctrl_ID) && !special;
    end

    ex_muldiv u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .start_i  (md_start),
        .abort_i  (ex.flush_EX),
        .op_i     (ex.alu_ctrl_ID),
        .word_i   (ex.word_ID),
        .a_i      (op_a),
        .b_i      (op_b),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .result_o (md_result)
    );

    always_comb begin
        res_d     = res_q;
        rd2_d     = rd2_q;
        pc_d      = pc_q;
        rd_d      = rd_q;
        rfsel_d   = rfsel_q;
        valid_d   = 1'b0;
        rfen_d    = 1'b0;
        dmrd_d    = '0;
        dmwr_d    = '0;
        h_pc_d    = h_pc_q;
        h_rs2_d   = h_rs2_q;
        h_rd_d    = h_rd_q;
        h_dmrd_d  = h_dmrd_q;
        h_dmwr_d  = h_dmwr_q;
        h_rfen_d  = h_rfen_q;
        h_rfsel_d = h_rfsel_q;
        if (!ex.flush_EX) begin
            if (md_done) begin
                res_d   = md_result;
                rd2_d   = h_rs2_q;
                pc_d    = h_pc_q;
                rd_d    = h_rd_q;
                dmrd_d  = h_dmrd_q;
                dmwr_d  = h_dmwr_q;
                rfen_d  = h_rfen_q;
                rfsel_d = h_rfsel_q;
                valid_d = 1'b1;
            end else if (md_start) begin
                h_pc_d    = ex.pc_ID;
                h_rs2_d   = ex.rs2_data_ID;
                h_rd_d    = ex.rd_ID;
                h_dmrd_d  = ex.dm_rd_ctrl_ID;
                h_dmwr_d  = ex.dm_wr_ctrl_ID;
                h_rfen_d  = ex.rf_wr_en_ID;
                h_rfsel_d = ex.rf_wr_sel_ID;
            end else if (accept) begin
                res_d   = fast_res;
                rd2_d   = ex.rs2_data_ID;
                pc_d    = ex.pc_ID;
                rd_d    = ex.rd_ID;
                dmrd_d  = ex.dm_rd_ctrl_ID;
                dmwr_d  = ex.dm_wr_ctrl_ID;
                rfen_d  = ex.rf_wr_en_ID;
                rfsel_d = ex.rf_wr_sel_ID;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_q     <= '0;
            rd2_q     <= '0;
            pc_q      <= '0;
            rd_q      <= '0;
            dmrd_q    <= '0;
            dmwr_q    <= '0;
            rfen_q    <= 1'b0;
            rfsel_q   <= '0;
            valid_q   <= 1'b0;
            h_pc_q    <= '0;
            h_rs2_q   <= '0;
            h_rd_q    <= '0;
            h_dmrd_q  <= '0;
            h_dmwr_q  <= '0;
            h_rfen_q  <= 1'b0;
            h_rfsel_q <= '0;
        end else begin
            res_q     <= res_d;
            rd2_q     <= rd2_d;
            pc_q      <= pc_d;
            rd_q      <= rd_d;
            dmrd_q    <= dmrd_d;
            dmwr_q    <= dmwr_d;
            rfen_q    <= rfen_d;
            rfsel_q   <= rfsel_d;
            valid_q   <= valid_d;
            h_pc_q    <= h_pc_d;
            h_rs2_q   <= h_rs2_d;
            h_rd_q    <= h_rd_d;
            h_dmrd_q  <= h_dmrd_d;
            h_dmwr_q  <= h_dmwr_d;
            h_rfen_q  <= h_rfen_d;
            h_rfsel_q <= h_rfsel_d;
        end
    end

    assign ex.alu_result_EX = res_q;
    assign ex.reg_data2_EX  = rd2_q;
    assign ex.pc_EX         = pc_q;
    assign ex.rd_EX         = rd_q;
    assign ex.dm_rd_ctrl_EX = dmrd_q;
    assign ex.dm_wr_ctrl_EX = dmwr_q;
    assign ex.rf_wr_en_EX   = rfen_q;
    assign ex.rf_wr_sel_EX  = rfsel_q;
    assign ex.valid_EX      = valid_q;
    assign ex.stall_EX      = md_busy;

endmodule

// File: tb/tb_pipeline_ex_stage.sv
// Directed bench for pipeline_ex_stage: single-cycle and iterative op tables
// plus hand-written stall, flush and mid-operation reset sequences.
module tb_pipeline_ex_stage;
    import rvcpu_ex_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pipeline_ex_stage_if ifc ();
    pipeline_ex_stage dut (.clk(clk), .reset(reset), .ex(ifc));

    typedef struct packed {
        logic [63:0] name;
        logic [4:0]  op;
        logic        word;
        logic        a_sel;
        logic        b_sel;
        logic [63:0] pc;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] imm;
        logic [63:0] exp;
    } vec_t;

    vec_t sc[$];
    vec_t mc[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic [63:0] nm, input logic [4:0] op, input logic w,
                                input logic as, input logic bs, input logic [63:0] pc,
                                input logic [63:0] rs1, input logic [63:0] rs2,
                                input logic [63:0] imm, input logic [63:0] exp);
        vec_t v;
        v.name = nm; v.op = op; v.word = w; v.a_sel = as; v.b_sel = bs;
        v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, want 0x%h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        ifc.valid_ID = 1'b0; ifc.flush_EX = 1'b0;
        ifc.pc_ID = '0; ifc.rs1_data_ID = '0; ifc.rs2_data_ID = '0; ifc.imm_ID = '0;
        ifc.rd_ID = '0; ifc.alu_ctrl_ID = '0; ifc.word_ID = 1'b0;
        ifc.a_sel_ID = 1'b0; ifc.b_sel_ID = 1'b0;
        ifc.dm_rd_ctrl_ID = '0; ifc.dm_wr_ctrl_ID = '0;
        ifc.rf_wr_en_ID = 1'b0; ifc.rf_wr_sel_ID = '0;
    endtask

    task automatic drive(input vec_t v, input logic [4:0] rd);
        ifc.valid_ID = 1'b1; ifc.alu_ctrl_ID = v.op; ifc.word_ID = v.word;
        ifc.a_sel_ID = v.a_sel; ifc.b_sel_ID = v.b_sel;
        ifc.pc_ID = v.pc; ifc.rs1_data_ID = v.rs1; ifc.rs2_data_ID = v.rs2; ifc.imm_ID = v.imm;
        ifc.rd_ID = rd; ifc.dm_rd_ctrl_ID = 3'b101; ifc.dm_wr_ctrl_ID = 2'b10;
        ifc.rf_wr_en_ID = 1'b1; ifc.rf_wr_sel_ID = 2'b01;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] side();
        return {49'b0, ifc.valid_EX, ifc.stall_EX, ifc.rf_wr_en_EX, ifc.rd_EX,
                ifc.dm_rd_ctrl_EX, ifc.dm_wr_ctrl_EX, ifc.rf_wr_sel_EX};
    endfunction

    function automatic logic [63:0] side_exp(input logic [4:0] rd);
        return {49'b0, 1'b1, 1'b0, 1'b1, rd, 3'b101, 2'b10, 2'b01};
    endfunction

    initial begin
        int   lat;
        int   stalls;
        logic seen;
        vec_t v;

        sc.push_back(mk("ADDimm",  ALU_ADD,   0, 0, 1, 64'h0, 64'd5, 64'd0, -64'sd7, 64'hFFFF_FFFF_FFFF_FFFE));
        sc.push_back(mk("ADDW",    ALU_ADD,   1, 0, 0, 64'h0, 64'h7FFF_FFFF, 64'd1, 64'h0, 64'hFFFF_FFFF_8000_0000));
        sc.push_back(mk("SUB",     ALU_SUB,   0, 0, 0, 64'h0, 64'd3, 64'd5, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE));
        sc.push_back(mk("SUBW",    ALU_SUB,   1, 0, 0, 64'h0, 64'h1_0000_0000, 64'd1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF));
        sc.push_back(mk("SLL",     ALU_SLL,   0, 0, 0, 64'h0, 64'd1, 64'h43, 64'h0, 64'd8));
        sc.push_back(mk("SLLW",    ALU_SLL,   1, 0, 0, 64'h0, 64'd1, 64'h3F, 64'h0, 64'hFFFF_FFFF_8000_0000));
        sc.push_back(mk("SRA",     ALU_SRA,   0, 0, 0, 64'h0, 64'h8000_0000_0000_0000, 64'd4, 64'h0, 64'hF800_0000_0000_0000));
        sc.push_back(mk("SRAW",    ALU_SRA,   1, 0, 0, 64'h0, 64'h8000_0000, 64'd1, 64'h0, 64'hFFFF_FFFF_C000_0000));
        sc.push_back(mk("SRLW",    ALU_SRL,   1, 0, 0, 64'h0, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'h0, 64'h0000_0000_0800_0000));
        sc.push_back(mk("SLT",     ALU_SLT,   0, 0, 0, 64'h0, '1, 64'd1, 64'h0, 64'd1));
        sc.push_back(mk("SLTU",    ALU_SLTU,  0, 0, 0, 64'h0, '1, 64'd1, 64'h0, 64'd0));
        sc.push_back(mk("XOR",     ALU_XOR,   0, 0, 0, 64'h0, 64'hF0, 64'hFF, 64'h0, 64'h0F));
        sc.push_back(mk("OR",      ALU_OR,    0, 0, 0, 64'h0, 64'hF0, 64'h0F, 64'h0, 64'hFF));
        sc.push_back(mk("AND",     ALU_AND,   0, 0, 0, 64'h0, 64'hF0, 64'h3C, 64'h0, 64'h30));
        sc.push_back(mk("PASSB",   ALU_PASSB, 0, 0, 1, 64'h0, 64'd9, 64'd3, 64'h1234, 64'h1234));
        sc.push_back(mk("AUIPC",   ALU_ADD,   0, 1, 1, 64'h1000, 64'd9, 64'd3, 64'd4, 64'h1004));
        sc.push_back(mk("DIVovf",  ALU_DIV,   0, 0, 0, 64'h0, 64'h8000_0000_0000_0000, '1, 64'h0, 64'h8000_0000_0000_0000));
        sc.push_back(mk("DIVU0",   ALU_DIVU,  0, 0, 0, 64'h0, 64'd7, 64'd0, 64'h0, '1));
        sc.push_back(mk("REMU0",   ALU_REMU,  0, 0, 0, 64'h0, 64'd7, 64'd0, 64'h0, 64'd7));
        sc.push_back(mk("REM0",    ALU_REM,   0, 0, 0, 64'h0, 64'd5, 64'd0, 64'h0, 64'd5));
        sc.push_back(mk("DIVWovf", ALU_DIV,   1, 0, 0, 64'h0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0, 64'hFFFF_FFFF_8000_0000));
        sc.push_back(mk("DIVUW0",  ALU_DIVU,  1, 0, 0, 64'h0, 64'd7, 64'h1_0000_0000, 64'h0, '1));
        sc.push_back(mk("UNKNOWN", 5'd11,     0, 0, 0, 64'h0, 64'd5, 64'd6, 64'h0, 64'd0));

        mc.push_back(mk("MUL",     ALU_MUL,    0, 0, 0, 64'h40, -64'sd3, 64'd5, 64'h0, 64'hFFFF_FFFF_FFFF_FFF1));
        mc.push_back(mk("MULH",    ALU_MULH,   0, 0, 0, 64'h44, '1, '1, 64'h0, 64'd0));
        mc.push_back(mk("MULHSU",  ALU_MULHSU, 0, 0, 0, 64'h48, '1, 64'd2, 64'h0, '1));
        mc.push_back(mk("MULW",    ALU_MUL,    1, 0, 0, 64'h4C, 64'h7FFF_FFFF, 64'd2, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE));
        mc.push_back(mk("DIV",     ALU_DIV,    0, 0, 0, 64'h50, -64'sd20, 64'd3, 64'h0, 64'hFFFF_FFFF_FFFF_FFFA));
        mc.push_back(mk("REM",     ALU_REM,    0, 0, 0, 64'h54, -64'sd20, 64'd3, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE));
        mc.push_back(mk("REMUbig", ALU_REMU,   0, 0, 0, 64'h58, '1, 64'h8000_0000_0000_0001, 64'h0, 64'h7FFF_FFFF_FFFF_FFFE));
        mc.push_back(mk("DIVUW",   ALU_DIVU,   1, 0, 0, 64'h5C, 64'hFFFF_FFFF_0000_0064, 64'd7, 64'h0, 64'hE));
        mc.push_back(mk("REMW",    ALU_REM,    1, 0, 0, 64'h60, -64'sd7, 64'd2, 64'h0, '1));

        idle_in();
        #2 reset = 1'b0;
        #2;
        chk("rst_result", ifc.alu_result_EX, 64'h0);
        chk("rst_side", side(), 64'h0);
        @(negedge clk);
        reset = 1'b1;

        foreach (sc[i]) begin
            drive(sc[i], 5'(i + 1));
            tick();
            chk($sformatf("%s", sc[i].name), ifc.alu_result_EX, sc[i].exp);
            chk($sformatf("%s_side", sc[i].name), side(), side_exp(5'(i + 1)));
            chk($sformatf("%s_pc_rs2", sc[i].name), ifc.pc_EX ^ ifc.reg_data2_EX, sc[i].pc ^ sc[i].rs2);
        end

        foreach (mc[i]) begin
            drive(mc[i], 5'(i + 10));
            tick();
            chk($sformatf("%s_bubble", mc[i].name), {62'b0, ifc.valid_EX, ifc.stall_EX}, 64'd1);
            idle_in();
            lat = 0;
            for (int k = 0; k < 80; k++) begin
                tick();
                lat++;
                if (ifc.valid_EX) break;
            end
            chk($sformatf("%s_lat", mc[i].name), 64'(lat), 64'd64);
            chk($sformatf("%s", mc[i].name), ifc.alu_result_EX, mc[i].exp);
            chk($sformatf("%s_side", mc[i].name), side(), side_exp(5'(i + 10)));
            chk($sformatf("%s_pc", mc[i].name), ifc.pc_EX, mc[i].pc);
        end

        // MULHU with an ADD waiting in ID for the whole stall
        drive(mk("MULHU", ALU_MULHU, 0, 0, 0, 64'h80, '1, '1, 64'h0, 64'h0), 5'd7);
        tick();
        stalls = ifc.stall_EX ? 1 : 0;
        drive(mk("ADDwait", ALU_ADD, 0, 0, 0, 64'h84, 64'd1, 64'd2, 64'h0, 64'h0), 5'd9);
        lat = 0;
        for (int k = 0; k < 80; k++) begin
            tick();
            lat++;
            if (ifc.stall_EX) stalls++;
            if (ifc.valid_EX) break;
        end
        chk("mulhu_stall_cycles", 64'(stalls), 64'd64);
        chk("mulhu_lat", 64'(lat), 64'd64);
        chk("mulhu_result", ifc.alu_result_EX, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("mulhu_rd", {59'b0, ifc.rd_EX}, 64'd7);
        tick();
        chk("add_after_stall", ifc.alu_result_EX, 64'd3);
        chk("add_after_stall_side", side(), side_exp(5'd9));

        idle_in();
        tick();
        chk("idle_bubble", {63'b0, ifc.valid_EX}, 64'd0);
        chk("idle_hold", ifc.alu_result_EX, 64'd3);

        drive(mk("ADDfl", ALU_ADD, 0, 0, 0, 64'h0, 64'd40, 64'd2, 64'h0, 64'h0), 5'd5);
        ifc.flush_EX = 1'b1;
        tick();
        chk("flush_idle_valid", {63'b0, ifc.valid_EX}, 64'd0);
        chk("flush_idle_hold", ifc.alu_result_EX, 64'd3);

        // DIV flushed at cnt=30 must never write back
        idle_in();
        drive(mk("DIVfl", ALU_DIV, 0, 0, 0, 64'h0, -64'sd20, 64'd3, 64'h0, 64'h0), 5'd4);
        tick();
        idle_in();
        repeat (30) tick();
        ifc.flush_EX = 1'b1;
        tick();
        ifc.flush_EX = 1'b0;
        chk("flush_busy_side", {61'b0, ifc.valid_EX, ifc.stall_EX, ifc.rf_wr_en_EX}, 64'd0);
        seen = 1'b0;
        for (int k = 0; k < 70; k++) begin
            tick();
            if (ifc.valid_EX || ifc.stall_EX) seen = 1'b1;
        end
        chk("flush_no_write", {63'b0, seen}, 64'd0);
        chk("flush_hold", ifc.alu_result_EX, 64'd3);

        // Reset asserted at cnt=10 of a DIVU clears everything without a clock
        drive(mk("DIVUrst", ALU_DIVU, 0, 0, 0, 64'h0, 64'd100, 64'd7, 64'h0, 64'h0), 5'd6);
        tick();
        idle_in();
        repeat (10) tick();
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_result", ifc.alu_result_EX, 64'h0);
        chk("rst_mid_side", side(), 64'h0);
        chk("rst_mid_pc_rs2", ifc.pc_EX | ifc.reg_data2_EX, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        v = mk("ADDrst", ALU_ADD, 0, 0, 0, 64'h0, 64'd2, 64'd3, 64'h0, 64'd5);
        drive(v, 5'd3);
        tick();
        chk("add_after_rst", ifc.alu_result_EX, 64'd5);
        chk("add_after_rst_side", side(), side_exp(5'd3));
        idle_in();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
